brick_scan_collider: RTL and testbench

Parametrised successor to the single-brick collision detector. On a `start` pulse it sweeps the whole brick RAM, reports the first (lowest-index) live brick the ball touches with its hit kind, and issues one write to clear that brick. It also reports paddle contact and the paddle zone that was struck. It sits between the ball-motion FSM, which pulses `start` once per frame and waits for `done`, and the brick RAM, which has one synchronous read port and one write port.

---
 rtl/breakout_pkg.sv | 28 ++
 rtl/brick_hit_check.sv | 63 ++++++
 rtl/brick_scan_collider.sv | 204 ++++++++++++++++++++
 tb/tb_brick_scan_collider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout collision blocks: brick record layout,
// hit-kind encodings and the scan FSM states.
package breakout_pkg;

  // Brick record is {x, pad, y, colour}; colour sits at the bottom.
  localparam int COLOUR_W   = 3;
  localparam int COLOUR_LSB = 0;
  localparam int Y_LSB      = COLOUR_LSB + COLOUR_W;

  function automatic int x_lsb(input int y_w);
    return Y_LSB + y_w + 1;
  endfunction

  typedef enum logic [1:0] {
    HIT_NONE = 2'b00,
    HIT_V    = 2'b01,
    HIT_H    = 2'b10,
    HIT_DIAG = 2'b11
  } hit_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CLEAR,
    ST_DONE
  } scan_state_e;

endpackage

// File: rtl/brick_hit_check.sv
// Combinational ball-versus-one-brick contact test; zero latency, no flow control.
// All edge arithmetic is one bit wider than the coordinates so wrap-around never matches.
module brick_hit_check
  import breakout_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int BRICK_W   = 16,
  parameter int BRICK_H   = 4,
  parameter int BALL_SIZE = 3
) (
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  input  logic           h_dir,
  input  logic           v_dir,
  input  logic [X_W-1:0] brick_x,
  input  logic [Y_W-1:0] brick_y,
  output hit_kind_e      hit_kind
);

  localparam int XE = X_W + 1;
  localparam int YE = Y_W + 1;

  logic [XE-1:0] ball_l, ball_r, ball_lo, ball_ro, brick_l, brick_r;
  logic [YE-1:0] ball_t, ball_b, ball_to, ball_bo, brick_t, brick_b;
  logic [XE-1:0] corner_x, target_x;
  logic [YE-1:0] corner_y, target_y;
  logic          x_ovl, y_ovl, diag, vert, horz;

  always_comb begin
    ball_l   = {1'b0, ball_x};
    ball_r   = ball_l + XE'(BALL_SIZE - 1);
    ball_lo  = ball_l - XE'(1);
    ball_ro  = ball_l + XE'(BALL_SIZE);
    brick_l  = {1'b0, brick_x};
    brick_r  = brick_l + XE'(BRICK_W - 1);
    ball_t   = {1'b0, ball_y};
    ball_b   = ball_t + YE'(BALL_SIZE - 1);
    ball_to  = ball_t - YE'(1);
    ball_bo  = ball_t + YE'(BALL_SIZE);
    brick_t  = {1'b0, brick_y};
    brick_b  = brick_t + YE'(BRICK_H - 1);

    x_ovl = (ball_l <= brick_r) && (ball_r >= brick_l);
    y_ovl = (ball_t <= brick_b) && (ball_b >= brick_t);

    // Leading corner of the one-pixel-expanded ball box against the facing brick corner.
    corner_x = h_dir ? ball_ro : ball_lo;
    target_x = h_dir ? brick_l : brick_r;
    corner_y = v_dir ? ball_bo : ball_to;
    target_y = v_dir ? brick_t : brick_b;
    diag     = (corner_x == target_x) && (corner_y == target_y);

    vert = x_ovl && ((ball_to == brick_b) || (ball_bo == brick_t));
    horz = y_ovl && ((ball_ro == brick_l) || (ball_lo == brick_r));

    hit_kind = HIT_NONE;
    if (diag)      hit_kind = HIT_DIAG;
    else if (vert) hit_kind = HIT_V;
    else if (horz) hit_kind = HIT_H;
  end

endmodule

// File: rtl/brick_scan_collider.sv
// Per-frame brick RAM sweep + paddle test; done at start+2 (skip), start+k+3 (hit k), start+NUM_BRICKS+2 (miss).
// start is ignored while busy; zone logic is built only with BRICK_SCAN_PADDLE_ZONE_EN.
module brick_scan_collider
  import breakout_pkg::*;
#(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int NUM_BRICKS   = 32,
  parameter int IDX_W        = 5,
  parameter int BRICK_W      = 16,
  parameter int BRICK_H      = 4,
  parameter int BALL_SIZE    = 3,
  parameter int PADDLE_W     = 20,
  parameter int BRICK_ZONE_Y = 34
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     ball_x,
  input  logic [Y_W-1:0]     ball_y,
  input  logic               h_dir,
  input  logic               v_dir,
  input  logic [X_W-1:0]     paddle_x,
  input  logic [Y_W-1:0]     paddle_y,
  output logic [IDX_W-1:0]   brick_addr,
  input  logic [X_W+Y_W+3:0] brick_data,
  output logic               clear_we,
  output logic [IDX_W-1:0]   clear_addr,
  output logic               busy,
  output logic               done,
  output logic               brick_hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [1:0]         hit_kind,
  output logic               paddle_hit,
  output logic [1:0]         paddle_zone
);

  localparam int XE    = X_W + 1;
  localparam int YE    = Y_W + 1;
  localparam int X_LSB = x_lsb(Y_W);

  scan_state_e       state_q, state_d;
  logic [IDX_W:0]    cnt_q, cnt_d, cnt_nxt;
  logic [X_W-1:0]    bx_q, bx_d, px_q, px_d;
  logic [Y_W-1:0]    by_q, by_d, py_q, py_d;
  logic              hd_q, hd_d, vd_q, vd_d;
  logic              brick_hit_q, brick_hit_d, paddle_hit_q, paddle_hit_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
  hit_kind_e         hit_kind_q, hit_kind_d, kind_c;
  logic              accept, first_scan, skip, live, paddle_c;
  logic              unused_pad;

  assign unused_pad = brick_data[Y_LSB + Y_W];

  brick_hit_check #(
    .X_W(X_W), .Y_W(Y_W), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .BALL_SIZE(BALL_SIZE)
  ) u_check (
    .ball_x  (bx_q),
    .ball_y  (by_q),
    .h_dir   (hd_q),
    .v_dir   (vd_q),
    .brick_x (brick_data[X_LSB +: X_W]),
    .brick_y (brick_data[Y_LSB +: Y_W]),
    .hit_kind(kind_c)
  );

  assign accept     = (state_q == ST_IDLE) && start;
  assign first_scan = (state_q == ST_SCAN) && (cnt_q == '0);
  assign skip       = by_q >= Y_W'(BRICK_ZONE_Y);
  assign live       = brick_data[COLOUR_LSB +: COLOUR_W] != '0;
  assign cnt_nxt    = cnt_q + (IDX_W+1)'(1);

  // Ball bottom row on the paddle row and horizontal spans overlapping.
  assign paddle_c = (({1'b0, by_q} + YE'(BALL_SIZE - 1)) == {1'b0, py_q}) &&
                    ({1'b0, bx_q} <= ({1'b0, px_q} + XE'(PADDLE_W - 1))) &&
                    (({1'b0, bx_q} + XE'(BALL_SIZE - 1)) >= {1'b0, px_q});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bx_d         = bx_q;
    by_d         = by_q;
    hd_d         = hd_q;
    vd_d         = vd_q;
    px_d         = px_q;
    py_d         = py_q;
    brick_hit_d  = brick_hit_q;
    hit_idx_d    = hit_idx_q;
    hit_kind_d   = hit_kind_q;
    paddle_hit_d = paddle_hit_q;
    brick_addr   = '0;
    clear_we     = 1'b0;
    clear_addr   = '0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bx_d         = ball_x;
          by_d         = ball_y;
          hd_d         = h_dir;
          vd_d         = v_dir;
          px_d         = paddle_x;
          py_d         = paddle_y;
          cnt_d        = '0;
          brick_hit_d  = 1'b0;
          hit_idx_d    = '0;
          hit_kind_d   = HIT_NONE;
          paddle_hit_d = 1'b0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (first_scan) paddle_hit_d = paddle_c;
        // cnt_q is the index whose record is on brick_data this cycle.
        if (skip || cnt_q == (IDX_W+1)'(NUM_BRICKS)) begin
          state_d = ST_DONE;
        end else if (live && kind_c != HIT_NONE) begin
          brick_hit_d = 1'b1;
          hit_idx_d   = cnt_q[IDX_W-1:0];
          hit_kind_d  = kind_c;
          state_d     = ST_CLEAR;
        end else begin
          cnt_d = cnt_nxt;
          if (cnt_nxt < (IDX_W+1)'(NUM_BRICKS)) brick_addr = cnt_nxt[IDX_W-1:0];
        end
      end
      ST_CLEAR: begin
        clear_we   = 1'b1;
        clear_addr = hit_idx_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      hd_q         <= 1'b0;
      vd_q         <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      brick_hit_q  <= 1'b0;
      hit_idx_q    <= '0;
      hit_kind_q   <= HIT_NONE;
      paddle_hit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      hd_q         <= hd_d;
      vd_q         <= vd_d;
      px_q         <= px_d;
      py_q         <= py_d;
      brick_hit_q  <= brick_hit_d;
      hit_idx_q    <= hit_idx_d;
      hit_kind_q   <= hit_kind_d;
      paddle_hit_q <= paddle_hit_d;
    end
  end

  assign busy       = (state_q == ST_SCAN) || (state_q == ST_CLEAR);
  assign brick_hit  = brick_hit_q;
  assign hit_idx    = hit_idx_q;
  assign hit_kind   = hit_kind_q;
  assign paddle_hit = paddle_hit_q;

`ifdef BRICK_SCAN_PADDLE_ZONE_EN
  logic signed [X_W+1:0] zone_ofs;
  logic [1:0]            zone_c, paddle_zone_q, paddle_zone_d;

  always_comb begin
    zone_ofs = $signed({2'b00, bx_q}) + $signed((X_W+2)'(BALL_SIZE / 2))
             - $signed({2'b00, px_q});
    zone_c = 2'd0;
    if (paddle_c) begin
      if (zone_ofs < $signed((X_W+2)'(PADDLE_W / 3)))          zone_c = 2'd0;
      else if (zone_ofs < $signed((X_W+2)'(2 * PADDLE_W / 3))) zone_c = 2'd1;
      else                                                     zone_c = 2'd2;
    end
    paddle_zone_d = paddle_zone_q;
    if (accept)          paddle_zone_d = 2'd0;
    else if (first_scan) paddle_zone_d = zone_c;
  end

  always_ff @(posedge clock) begin
    if (reset) paddle_zone_q <= 2'd0;
    else       paddle_zone_q <= paddle_zone_d;
  end

  assign paddle_zone = paddle_zone_q;
`else
  assign paddle_zone = 2'd1;
`endif

endmodule

// File: tb/tb_brick_scan_collider.sv
// Bench for brick_scan_collider: directed frames from the test plan plus random frames
// checked against an integer-arithmetic collision model and a behavioural brick RAM.
module tb_brick_scan_collider;

  localparam int N    = 32;
  localparam int BW   = 16;
  localparam int BH   = 4;
  localparam int B    = 3;
  localparam int PW   = 20;
  localparam int ZONE = 34;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ball_x = '0, paddle_x = '0;
  logic [6:0]  ball_y = '0, paddle_y = '0;
  logic        h_dir = 1'b0, v_dir = 1'b0;
  logic [4:0]  brick_addr, clear_addr, hit_idx;
  logic [18:0] brick_data = '0;
  logic        clear_we, busy, done, brick_hit, paddle_hit;
  logic [1:0]  hit_kind, paddle_zone;

  logic [18:0] mem [N];
  int n_cmp = 0;
  int n_bad = 0;

  brick_scan_collider dut (
    .clock(clock), .reset(reset), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .h_dir(h_dir), .v_dir(v_dir),
    .paddle_x(paddle_x), .paddle_y(paddle_y),
    .brick_addr(brick_addr), .brick_data(brick_data),
    .clear_we(clear_we), .clear_addr(clear_addr),
    .busy(busy), .done(done),
    .brick_hit(brick_hit), .hit_idx(hit_idx), .hit_kind(hit_kind),
    .paddle_hit(paddle_hit), .paddle_zone(paddle_zone)
  );

  always #5 clock = ~clock;

  always @(posedge clock) brick_data <= mem[brick_addr];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] rec(input int x, input int y, input int c);
    logic [7:0] xv;
    logic [6:0] yv;
    logic [2:0] cv;
    xv = x[7:0];
    yv = y[6:0];
    cv = c[2:0];
    return {xv, 1'b0, yv, cv};
  endfunction

  // Contact kind for the ball against one brick, straight from the geometric rules.
  function automatic int model_kind(input int bx, input int by, input int h, input int v,
                                    input int x, input int y);
    int cx, cy, tx, ty;
    bit x_ovl, y_ovl;
    cx = h ? bx + B : bx - 1;
    cy = v ? by + B : by - 1;
    tx = h ? x : x + BW - 1;
    ty = v ? y : y + BH - 1;
    if (cx == tx && cy == ty) return 3;
    x_ovl = (bx <= x + BW - 1) && (bx + B - 1 >= x);
    y_ovl = (by <= y + BH - 1) && (by + B - 1 >= y);
    if (x_ovl && (by - 1 == y + BH - 1 || by + B == y)) return 1;
    if (y_ovl && (bx + B == x || bx - 1 == x + BW - 1)) return 2;
    return 0;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic run_frame(input string tag, input int bx, input int by, input int h,
                           input int v, input int px, input int py, input bit poke);
    int exp_idx, exp_kind, exp_done, exp_ph, exp_zone, o;
    int done_cyc, clr_cyc, clr_addr, n_clr;
    bit got_done, addr_moved;
    exp_idx = -1;
    exp_kind = 0;
    if (by < ZONE) begin
      for (int i = 0; i < N; i++) begin
        int k;
        if (mem[i][2:0] == 0 || exp_idx >= 0) continue;
        k = model_kind(bx, by, h, v, int'(mem[i][18:11]), int'(mem[i][9:3]));
        if (k != 0) begin
          exp_idx = i;
          exp_kind = k;
        end
      end
    end
    exp_done = (by >= ZONE) ? 2 : (exp_idx >= 0) ? exp_idx + 3 : N + 2;
    exp_ph = (by + B - 1 == py) && (bx <= px + PW - 1) && (bx + B - 1 >= px);
`ifdef BRICK_SCAN_PADDLE_ZONE_EN
    o = bx + B / 2 - px;
    exp_zone = !exp_ph ? 0 : (o < PW / 3) ? 0 : (o < 2 * PW / 3) ? 1 : 2;
`else
    o = 0;
    exp_zone = 1 + o;
`endif
    if (exp_done <= 5) poke = 1'b0;

    @(negedge clock);
    ball_x = 8'(bx); ball_y = 7'(by); h_dir = h[0]; v_dir = v[0];
    paddle_x = 8'(px); paddle_y = 7'(py);
    start = 1'b1;
    got_done = 0; addr_moved = 0; n_clr = 0; done_cyc = -1; clr_cyc = -1; clr_addr = -1;
    for (int c = 1; c <= 100 && !got_done; c++) begin
      @(negedge clock);
      start = poke && (c == 3);
      if (clear_we) begin
        n_clr++;
        clr_cyc = c;
        clr_addr = int'(clear_addr);
      end
      if (brick_addr != 0) addr_moved = 1;
      if (done) begin
        got_done = 1;
        done_cyc = c;
      end
    end
    start = 1'b0;
    if (!got_done) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_clear_count"}, n_clr, (exp_idx >= 0) ? 1 : 0);
    if (exp_idx >= 0) begin
      check({tag, "_clear_cycle"}, clr_cyc, exp_idx + 2);
      check({tag, "_clear_addr"}, clr_addr, exp_idx);
      mem[exp_idx] = '0;
    end
    if (by >= ZONE) check({tag, "_addr_moved"}, int'(addr_moved), 0);
    check({tag, "_brick_hit"}, int'(brick_hit), (exp_idx >= 0) ? 1 : 0);
    check({tag, "_hit_idx"}, int'(hit_idx), (exp_idx >= 0) ? exp_idx : 0);
    check({tag, "_hit_kind"}, int'(hit_kind), exp_kind);
    check({tag, "_paddle_hit"}, int'(paddle_hit), exp_ph);
    check({tag, "_paddle_zone"}, int'(paddle_zone), exp_zone);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    repeat (3) @(negedge clock);
    check({tag, "_no_restart"}, int'(busy || done), 0);
    check({tag, "_hold_hit"}, int'(brick_hit), (exp_idx >= 0) ? 1 : 0);
  endtask

  initial begin
    int zone_rst, n_clr, n_done;
    clear_mem();
`ifdef BRICK_SCAN_PADDLE_ZONE_EN
    zone_rst = 0;
`else
    zone_rst = 1;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_clear_we", int'(clear_we), 0);
    check("rst_brick_addr", int'(brick_addr), 0);
    check("rst_brick_hit", int'(brick_hit), 0);
    check("rst_hit_kind", int'(hit_kind), 0);
    check("rst_paddle_hit", int'(paddle_hit), 0);
    check("rst_paddle_zone", int'(paddle_zone), zone_rst);

    clear_mem(); mem[5] = rec(40, 20, 3);
    run_frame("vert", 45, 24, 1, 0, 0, 100, 0);
    clear_mem(); mem[0] = rec(40, 20, 3);
    run_frame("diag", 37, 17, 1, 1, 0, 100, 0);
    clear_mem(); mem[2] = rec(40, 20, 3); mem[7] = rec(38, 19, 5);
    run_frame("horz", 37, 20, 1, 0, 0, 100, 0);
    clear_mem(); mem[5] = rec(40, 20, 0);
    run_frame("dead", 45, 24, 1, 0, 0, 100, 0);
    clear_mem(); mem[0] = rec(40, 48, 3);
    run_frame("skip", 45, 50, 1, 0, 0, 100, 0);
    clear_mem();
    run_frame("paddle", 75, 108, 1, 1, 60, 110, 0);
    clear_mem(); mem[9] = rec(40, 20, 2);
    run_frame("busy_start", 45, 24, 0, 0, 0, 100, 1);
    clear_mem();
    run_frame("ball_x0", 0, 20, 0, 0, 0, 100, 0);

    // Reset in the middle of a scan with a hit pending at index 6.
    clear_mem(); mem[6] = rec(40, 20, 3);
    @(negedge clock);
    ball_x = 8'd45; ball_y = 7'd24; h_dir = 1'b1; v_dir = 1'b0;
    paddle_x = 8'd40; paddle_y = 7'd26;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_brick_hit", int'(brick_hit), 0);
    check("abort_paddle_hit", int'(paddle_hit), 0);
    check("abort_paddle_zone", int'(paddle_zone), zone_rst);
    check("abort_clear_addr", int'(clear_addr), 0);
    n_clr = 0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (clear_we) n_clr++;
      if (done) n_done++;
    end
    check("abort_no_clear", n_clr, 0);
    check("abort_no_done", n_done, 0);

    for (int f = 0; f < 40; f++) begin
      int j, bx, by, px, py;
      for (int i = 0; i < N; i++)
        mem[i] = rec($urandom_range(0, 250), $urandom_range(0, 36),
                     ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7));
      j = $urandom_range(0, N - 1);
      bx = int'(mem[j][18:11]) + $urandom_range(0, BW + 6) - 4;
      by = int'(mem[j][9:3]) + $urandom_range(0, BH + 6) - 4;
      if (bx < 0) bx = 0;
      if (bx > 255) bx = 255;
      if (by < 0) by = 0;
      if ($urandom_range(0, 4) == 0) by = $urandom_range(30, 127);
      px = bx - $urandom_range(0, PW + 2);
      if (px < 0) px = 0;
      py = ($urandom_range(0, 1) == 1) ? by + B - 1 : $urandom_range(0, 127);
      if (py > 127) py = 127;
      run_frame("rand", bx, by, $urandom_range(0, 1), $urandom_range(0, 1), px, py,
                $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
